// File: rtl/easy_fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write arbiter.
package easy_fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Widest requester vector the pick helper handles.
  localparam int RR_MAX_SRC = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                       input logic [3:0]            ptr,
                                       input int                    n);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int k = 0; k < RR_MAX_SRC; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !res.found && req[j]) begin
        res.found = 1'b1;
        res.idx   = j[3:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/easy_fifo_rr_picker.sv
// Combinational rotate + priority encoder: first requester at or after the pointer.
module easy_fifo_rr_picker
  import easy_fifo_arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
)(
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  rr_pick_t w_res;

  assign w_res   = rr_pick(RR_MAX_SRC'(i_req), 4'(i_ptr), N);
  assign o_found = w_res.found;
  assign o_idx   = W'(w_res.idx);

endmodule

// File: rtl/easy_fifo_axis_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_SRC AXI-stream
// requesters. A grant is held until tlast or until MAX_BURST beats are written.
module easy_fifo_axis_wr_arbiter
  import easy_fifo_arb_pkg::*;
#(
  parameter  int NUM_SRC   = 4,
  parameter  int DWIDTH    = 32,
  parameter  int MAX_BURST = 16,
  localparam int SRC_W     = $clog2(NUM_SRC)
)(
  input  logic                      rst,
  input  logic                      wr_clk_int,
  input  logic [NUM_SRC*DWIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic [DWIDTH-1:0]         fifo_wr_data,
  output logic [SRC_W-1:0]          fifo_wr_src,
  output logic                      fifo_wr_last,
  output logic                      fifo_wr_en,
  input  logic                      fifo_wr_full,
  output logic                      grant_active,
  output logic [SRC_W-1:0]          grant_idx
);

  // MAX_BURST=0 (unlimited) still needs a legal counter width.
  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  arb_state_t       r_state, w_state_nxt;
  logic [SRC_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [SRC_W-1:0] r_grant_idx, w_grant_nxt;
  logic [SRC_W-1:0] w_pick_idx;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic             w_found, w_locked, w_beat, w_burst_cut, w_release;

  easy_fifo_rr_picker #(.N(NUM_SRC)) u_picker (
    .i_req   (s_tvalid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  assign w_locked    = (r_state == ARB_LOCKED);
  assign w_beat      = w_locked & s_tvalid[r_grant_idx] & ~fifo_wr_full;
  assign w_burst_cut = (MAX_BURST > 0) && (int'(r_beat_cnt) + 1 == MAX_BURST);
  assign w_release   = w_beat & (s_tlast[r_grant_idx] | w_burst_cut);

  // Next-state: arbitrate in IDLE, count beats and release in LOCKED.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant_idx;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state_nxt    = ARB_LOCKED;
          w_grant_nxt    = w_pick_idx;
          w_beat_cnt_nxt = '0;
        end
      end
      ARB_LOCKED: begin
        if (w_beat && r_beat_cnt != '1)
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        if (w_release) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = (r_grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : r_grant_idx + 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // State, pointer, grant and beat counter registers.
  always_ff @(posedge wr_clk_int or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_beat_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_grant_idx <= w_grant_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
    end
  end

  // Ready goes only to the granted source and never looks at s_tvalid.
  always_comb begin
    s_tready = '0;
    if (w_locked && !fifo_wr_full)
      s_tready[r_grant_idx] = 1'b1;
  end

  assign fifo_wr_en   = w_beat;
  assign fifo_wr_data = s_tdata[r_grant_idx*DWIDTH +: DWIDTH];
  assign fifo_wr_src  = r_grant_idx;
  assign fifo_wr_last = w_release;
  assign grant_active = w_locked;
  assign grant_idx    = r_grant_idx;

endmodule

// File: tb/tb_easy_fifo_axis_wr_arbiter.sv
// Directed bench for the FIFO write arbiter (NUM_SRC=4, MAX_BURST=4).
module tb_easy_fifo_axis_wr_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int SW = 2;

  logic             rst, wr_clk_int;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]    fifo_wr_data;
  logic [SW-1:0]    fifo_wr_src, grant_idx;
  logic             fifo_wr_last, fifo_wr_en, fifo_wr_full, grant_active;

  easy_fifo_axis_wr_arbiter #(.NUM_SRC(NS), .DWIDTH(DW), .MAX_BURST(MB)) dut (
    .rst          (rst),
    .wr_clk_int   (wr_clk_int),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_src  (fifo_wr_src),
    .fifo_wr_last (fifo_wr_last),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_full (fifo_wr_full),
    .grant_active (grant_active),
    .grant_idx    (grant_idx)
  );

  initial wr_clk_int = 1'b0;
  always #5 wr_clk_int = ~wr_clk_int;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source model: per-source beat queues; a source presents its head beat.
  logic [31:0] q_data[NS][$];
  logic        q_last[NS][$];
  logic [NS-1:0] hold, pend;
  logic          full_drv;
  int            cyc;

  // Observed beats and expected beats.
  int          lg_cyc[$], lg_src[$];
  logic [31:0] lg_data[$];
  logic        lg_last[$];
  int          ex_cyc[$], ex_src[$];
  logic [31:0] ex_data[$];
  logic        ex_last[$];

  // One cycle: retire last handshake, drive inputs, sample outputs 1ns later.
  task automatic step();
    logic [31:0] d;
    logic        l;
    @(negedge wr_clk_int);
    for (int i = 0; i < NS; i++) begin
      if (pend[i]) begin
        d = q_data[i].pop_front();
        l = q_last[i].pop_front();
      end
      s_tvalid[i]          = (q_data[i].size() > 0) && !hold[i];
      s_tdata[i*DW +: DW]  = (q_data[i].size() > 0) ? q_data[i][0] : 32'h0;
      s_tlast[i]           = (q_data[i].size() > 0) ? q_last[i][0] : 1'b0;
    end
    fifo_wr_full = full_drv;
    #1;
    if (fifo_wr_en) begin
      lg_cyc.push_back(cyc);
      lg_src.push_back(int'(fifo_wr_src));
      lg_data.push_back(fifo_wr_data);
      lg_last.push_back(fifo_wr_last);
    end
    pend = s_tvalid & s_tready;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push_pkt(input int src, input int n, input int base);
    for (int b = 0; b < n; b++) begin
      q_data[src].push_back((32'(src) << 8) | 32'(base + b));
      q_last[src].push_back(b == n - 1);
    end
  endtask

  task automatic ex(input int c, input int s, input logic [31:0] d, input logic l);
    ex_cyc.push_back(c); ex_src.push_back(s); ex_data.push_back(d); ex_last.push_back(l);
  endtask

  task automatic clear_logs();
    lg_cyc.delete(); lg_src.delete(); lg_data.delete(); lg_last.delete();
    ex_cyc.delete(); ex_src.delete(); ex_data.delete(); ex_last.delete();
  endtask

  task automatic check_log(input string tag);
    chk($sformatf("%s.nbeats", tag), 32'(lg_cyc.size()), 32'(ex_cyc.size()));
    for (int k = 0; k < ex_cyc.size() && k < lg_cyc.size(); k++) begin
      chk($sformatf("%s[%0d].cyc", tag, k),  32'(lg_cyc[k]), 32'(ex_cyc[k]));
      chk($sformatf("%s[%0d].src", tag, k),  32'(lg_src[k]), 32'(ex_src[k]));
      chk($sformatf("%s[%0d].data", tag, k), lg_data[k],     ex_data[k]);
      chk($sformatf("%s[%0d].last", tag, k), 32'(lg_last[k]), 32'(ex_last[k]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend = '0; hold = '0; full_drv = 1'b0;
    for (int i = 0; i < NS; i++) begin
      q_data[i].delete();
      q_last[i].delete();
    end
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; fifo_wr_full = 1'b0;
    @(negedge wr_clk_int);
    @(negedge wr_clk_int);
    rst = 1'b0;
    clear_logs();
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hold = '0; pend = '0; full_drv = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; fifo_wr_full = 1'b0;
    @(negedge wr_clk_int);
    @(negedge wr_clk_int);
    // Reset values
    chk("rst.tready", 32'(s_tready), 32'h0);
    chk("rst.wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst.gact", 32'(grant_active), 32'h0);
    chk("rst.gidx", 32'(grant_idx), 32'h0);
    chk("rst.rr_ptr", 32'(dut.r_rr_ptr), 32'h0);

    // T1: lone src2, 3-beat packet
    do_reset();
    push_pkt(2, 3, 0);
    run(5);
    ex(1, 2, 32'h200, 1'b0); ex(2, 2, 32'h201, 1'b0); ex(3, 2, 32'h202, 1'b1);
    check_log("t1");
    chk("t1.gact", 32'(grant_active), 32'h0);
    chk("t1.gidx", 32'(grant_idx), 32'h2);
    chk("t1.rr_ptr", 32'(dut.r_rr_ptr), 32'h3);

    // T2: all sources with 2-beat packets, src0 has a second one (wrap)
    do_reset();
    for (int s = 0; s < NS; s++) push_pkt(s, 2, 0);
    push_pkt(0, 2, 2);
    run(16);
    for (int p = 0; p < 5; p++) begin
      ex(3*p + 1, p % 4, (32'(p % 4) << 8) | ((p == 4) ? 32'h2 : 32'h0), 1'b0);
      ex(3*p + 2, p % 4, (32'(p % 4) << 8) | ((p == 4) ? 32'h3 : 32'h1), 1'b1);
    end
    check_log("t2");

    // T3: burst cuts on a 10-beat src1 packet with src2/src3 competing
    do_reset();
    push_pkt(1, 10, 0);
    push_pkt(2, 2, 0);
    push_pkt(3, 1, 0);
    run(19);
    for (int b = 0; b < 4; b++) ex(1 + b, 1, 32'h100 + 32'(b), b == 3);
    ex(6, 2, 32'h200, 1'b0); ex(7, 2, 32'h201, 1'b1);
    ex(9, 3, 32'h300, 1'b1);
    for (int b = 0; b < 4; b++) ex(11 + b, 1, 32'h104 + 32'(b), b == 3);
    ex(16, 1, 32'h108, 1'b0); ex(17, 1, 32'h109, 1'b1);
    check_log("t3");

    // T3b: tlast coincides with the burst limit
    do_reset();
    push_pkt(0, 4, 0);
    push_pkt(1, 1, 0);
    run(8);
    for (int b = 0; b < 4; b++) ex(1 + b, 0, 32'(b), b == 3);
    ex(6, 1, 32'h100, 1'b1);
    check_log("t3b");

    // T4: FIFO full for 3 cycles mid-packet
    do_reset();
    push_pkt(2, 4, 0);
    run(2);
    full_drv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t4.full%0d.tready", k), 32'(s_tready), 32'h0);
      chk($sformatf("t4.full%0d.wr_en", k), 32'(fifo_wr_en), 32'h0);
      chk($sformatf("t4.full%0d.gact", k), 32'(grant_active), 32'h1);
      chk($sformatf("t4.full%0d.bcnt", k), 32'(dut.r_beat_cnt), 32'h1);
    end
    full_drv = 1'b0;
    run(4);
    ex(1, 2, 32'h200, 1'b0); ex(5, 2, 32'h201, 1'b0);
    ex(6, 2, 32'h202, 1'b0); ex(7, 2, 32'h203, 1'b1);
    check_log("t4");

    // T5: reset after beat 2 of a 5-beat src3 packet
    do_reset();
    push_pkt(3, 5, 0);
    run(3);
    @(posedge wr_clk_int);
    #2;
    rst = 1'b1;
    #1;
    chk("t5.tready", 32'(s_tready), 32'h0);
    chk("t5.wr_en", 32'(fifo_wr_en), 32'h0);
    chk("t5.gact", 32'(grant_active), 32'h0);
    chk("t5.gidx", 32'(grant_idx), 32'h0);
    chk("t5.rr_ptr", 32'(dut.r_rr_ptr), 32'h0);
    ex(1, 3, 32'h300, 1'b0); ex(2, 3, 32'h301, 1'b0);
    check_log("t5a");
    do_reset();
    push_pkt(3, 2, 0);
    push_pkt(1, 1, 0);
    push_pkt(2, 1, 0);
    run(8);
    ex(1, 1, 32'h100, 1'b1);
    ex(3, 2, 32'h200, 1'b1);
    ex(5, 3, 32'h300, 1'b0); ex(6, 3, 32'h301, 1'b1);
    check_log("t5b");

    // T6: granted src0 stalls its tvalid while src1 waits
    do_reset();
    push_pkt(0, 3, 0);
    push_pkt(1, 1, 0);
    run(2);
    hold[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t6.stall%0d.gact", k), 32'(grant_active), 32'h1);
      chk($sformatf("t6.stall%0d.gidx", k), 32'(grant_idx), 32'h0);
      chk($sformatf("t6.stall%0d.tready", k), 32'(s_tready), 32'h1);
    end
    hold[0] = 1'b0;
    run(5);
    ex(1, 0, 32'h000, 1'b0); ex(7, 0, 32'h001, 1'b0); ex(8, 0, 32'h002, 1'b1);
    ex(10, 1, 32'h100, 1'b1);
    check_log("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/easy_fifo_axis_wr_arbiter.md
Name: easy_fifo_axis_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of one async FIFO between NUM_SRC AXI-stream requesters, all in the write clock domain.
- Grants one source at a time and holds the grant until that source's tlast beat, or until MAX_BURST beats have been written.
- Drives the FIFO write interface directly and tags every beat with its source index and last flag, so the read side can demultiplex.

Parameters:
- NUM_SRC, 4: number of requesters, 2..16.
- DWIDTH, 32: payload width per beat.
- MAX_BURST, 16: maximum beats per grant; 0 means unlimited (grant released only on tlast).
- SRC_W, $clog2(NUM_SRC): width of the source tag (derived, not overridden).

Ports:
- rst  in  1  asynchronous reset, active-high
- wr_clk_int  in  1  write-domain clock; all logic on its rising edge
- s_tdata  in  NUM_SRC*DWIDTH  packed source payloads; source i occupies bits [i*DWIDTH +: DWIDTH]
- s_tvalid  in  NUM_SRC  per-source valid
- s_tlast  in  NUM_SRC  per-source end-of-packet
- s_tready  out  NUM_SRC  per-source ready
- fifo_wr_data  out  DWIDTH  payload to the FIFO
- fifo_wr_src  out  SRC_W  source tag of the current beat
- fifo_wr_last  out  1  last flag of the current beat (tlast, or burst-limit cut)
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_full  in  1  FIFO full
- grant_active  out  1  high while in the LOCKED state
- grant_idx  out  SRC_W  index of the currently or last granted source

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0, grant_active=0, s_tready=0, fifo_wr_en=0. fifo_wr_data, fifo_wr_src and fifo_wr_last are don't-care while fifo_wr_en=0.
- State machine has two states, IDLE and LOCKED.
- IDLE:
  - If any s_tvalid is high, select the first valid source scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - Register that index into grant_idx, clear beat_cnt, go to LOCKED next cycle.
  - No transfer happens in IDLE.
- LOCKED datapath (combinational from grant_idx):
  - s_tready[grant_idx] = ~fifo_wr_full; all other s_tready bits are 0.
  - fifo_wr_en = s_tvalid[grant_idx] & ~fifo_wr_full.
  - fifo_wr_data is the granted slice; fifo_wr_src = grant_idx.
- Beat: a beat is a cycle with fifo_wr_en=1. Each beat increments beat_cnt, which is $clog2(MAX_BURST+1) bits and saturates.
- Release: LOCKED goes to IDLE on the clock edge after a beat where either
  - s_tlast[grant_idx]=1, or
  - MAX_BURST>0 and beat_cnt+1 == MAX_BURST.
  - On release, rr_ptr = (grant_idx+1) mod NUM_SRC.
  - fifo_wr_last = s_tlast[grant_idx] | burst_cut, asserted on that beat only.
- Latency: one dead cycle per grant for arbitration. Back-to-back packets from different sources are separated by exactly one idle cycle.
- Boundary conditions:
  - fifo_wr_full high in LOCKED: no beat, grant held, beat_cnt unchanged.
  - Granted source drops tvalid mid-packet: grant held indefinitely; the packet is never interleaved.
  - tlast and the burst limit on the same beat: single release, and fifo_wr_last is 1 once.
  - Single-beat packet (tlast on the first beat): one beat, then release.
  - Pointer wrap: rr_ptr = NUM_SRC-1 wraps to 0.
  - rst asserted mid-packet: immediate return to the reset values. The partial packet is truncated and the write side does not track it; the FIFO is reset by the same rst.
- No combinational path from s_tvalid to s_tready. s_tready depends only on state, grant_idx and fifo_wr_full.

Decomposition:
- Package easy_fifo_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t
  - function rr_pick(req, ptr), returning the first set bit at or after ptr with wrap, plus a found flag.
- One sub-module, easy_fifo_rr_picker: a combinational rotate and priority encoder, reusable by a future read-side scheduler.
- The FSM, counters and muxing stay in the top module.

Test Plan:
- NUM_SRC=4, only src2 sends a 3-beat packet (tlast on beat 3) with FIFO not full:
  - grant in cycle 1, beats in cycles 2-4 with fifo_wr_src=2, fifo_wr_last on beat 3 only, rr_ptr=3 afterwards.
- All four sources hold 2-beat packets from reset:
  - grant order 0,1,2,3,0; beats tagged accordingly; exactly one idle cycle between packets.
- MAX_BURST=4, src1 sends a 10-beat packet:
  - cuts after beats 4 and 8, fifo_wr_last high on beats 4, 8 and 10; src1 is regranted only after the other valid sources are served.
- fifo_wr_full pulsed high for 3 cycles mid-packet:
  - s_tready[g]=0 and fifo_wr_en=0 for those cycles; no beat lost or duplicated; beat_cnt frozen.
- rst asserted after beat 2 of a 5-beat src3 packet:
  - next cycle all s_tready=0, fifo_wr_en=0, rr_ptr=0; after release the first grant goes to the lowest valid source.
- src0 granted, then deasserts tvalid for 5 cycles mid-packet while src1 is valid:
  - src1 never granted until src0's tlast beat; then src1 is granted after one idle cycle.
